// File: rtl/dac_playback_buffer_if.sv
// Load, control and DAC playback signals of dac_playback_buffer.
// The master side is the loader/controller, the slave side is the buffer.
interface dac_playback_buffer_if #(
   parameter int unsigned DWIDTH       = 256,
   parameter int unsigned BUFFER_DEPTH = 1024
);
   localparam int unsigned CntW = $clog2(BUFFER_DEPTH) + 1;

   logic [DWIDTH-1:0] load_data;
   logic              load_valid;
   logic              load_ready;
   logic              load_last;
   logic [CntW-1:0]   load_depth;
   logic              load_depth_valid;
   logic              arm;
   logic              loop_mode;
   logic              sw_reset;
   logic              hw_start;
   logic              hw_stop;
   logic [DWIDTH-1:0] dac_data;
   logic              dac_valid;
   logic              playback_done;

   modport master (
      output load_data, load_valid, load_last, arm, loop_mode, sw_reset, hw_start, hw_stop,
      input  load_ready, load_depth, load_depth_valid, dac_data, dac_valid, playback_done
   );

   modport slave (
      input  load_data, load_valid, load_last, arm, loop_mode, sw_reset, hw_start, hw_stop,
      output load_ready, load_depth, load_depth_valid, dac_data, dac_valid, playback_done
   );
endinterface

// File: rtl/dac_playback_buffer.sv
// DAC playback buffer: a waveform is loaded into local memory, then played out
// once or looped after arm + hw_start, through a fixed-latency read pipeline.
module dac_playback_buffer #(
   parameter int unsigned DWIDTH       = 256,
   parameter int unsigned BUFFER_DEPTH = 1024,
   parameter int unsigned READ_LATENCY = 4
) (
   input logic                 dac_clk,
   input logic                 dac_reset_n,
   dac_playback_buffer_if.slave bus
);
   localparam int unsigned AddrW = $clog2(BUFFER_DEPTH);
   localparam int unsigned CntW  = AddrW + 1;
   // Pipeline holds only the word about to leave dac_data
   localparam logic [READ_LATENCY-1:0] OnlyLast = READ_LATENCY'(1) << (READ_LATENCY - 1);

   typedef enum logic [2:0] {StEmpty, StLoading, StLoaded, StArmed, StPlaying} state_e;

   state_e                  state_q;
   logic [AddrW-1:0]        wr_addr_q;
   logic [AddrW-1:0]        rd_addr_q;
   logic                    loop_q;
   logic [CntW-1:0]         depth_q;
   logic                    depth_valid_q;
   logic                    pending_q;
   logic                    done_q;
   logic [DWIDTH-1:0]       mem [BUFFER_DEPTH];
   logic [DWIDTH-1:0]       pipe_data_q [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_valid_q;

   logic             load_ready;
   logic             beat;
   logic             load_done;
   logic             issue;
   logic             issue_last;
   logic             loop_now;
   logic             done_now;
   logic [AddrW-1:0] issue_addr;

   // Load handshake, read issue and drain detection
   always_comb begin
      load_ready = dac_reset_n && !bus.sw_reset && (state_q == StEmpty || state_q == StLoading);
      beat       = load_ready && bus.load_valid;
      load_done  = beat && (bus.load_last || wr_addr_q == AddrW'(BUFFER_DEPTH - 1));
      issue      = 1'b0;
      issue_addr = rd_addr_q;
      if (!bus.sw_reset && !bus.hw_stop) begin
         if (state_q == StArmed && bus.hw_start) begin
            issue      = 1'b1;
            issue_addr = '0;
         end else if (state_q == StPlaying) begin
            issue = 1'b1;
         end
      end
      // loop_mode is sampled on the start cycle itself
      loop_now   = (state_q == StArmed) ? bus.loop_mode : loop_q;
      issue_last = issue && ({1'b0, issue_addr} == depth_q - CntW'(1));
      done_now   = pending_q && (pipe_valid_q == OnlyLast) && !issue;
   end

   // Control FSM with registered status outputs
   always_ff @(posedge dac_clk or negedge dac_reset_n) begin
      if (!dac_reset_n) begin
         state_q       <= StEmpty;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         loop_q        <= 1'b0;
         depth_q       <= '0;
         depth_valid_q <= 1'b0;
         pending_q     <= 1'b0;
         done_q        <= 1'b0;
      end else if (bus.sw_reset) begin
         state_q       <= StEmpty;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         depth_q       <= '0;
         depth_valid_q <= 1'b0;
         pending_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         depth_valid_q <= 1'b0;
         done_q        <= done_now;
         if (done_now) pending_q <= 1'b0;
         unique case (state_q)
            StEmpty, StLoading: begin
               if (beat) begin
                  if (load_done) begin
                     state_q       <= StLoaded;
                     wr_addr_q     <= '0;
                     depth_q       <= {1'b0, wr_addr_q} + CntW'(1);
                     depth_valid_q <= 1'b1;
                  end else begin
                     state_q   <= StLoading;
                     wr_addr_q <= wr_addr_q + AddrW'(1);
                  end
               end
            end
            StLoaded: begin
               if (bus.arm) state_q <= StArmed;
            end
            StArmed, StPlaying: begin
               if (issue) begin
                  if (state_q == StArmed) loop_q <= bus.loop_mode;
                  if (issue_last && !loop_now) begin
                     state_q   <= StLoaded;
                     rd_addr_q <= '0;
                     pending_q <= 1'b1;
                  end else begin
                     state_q   <= StPlaying;
                     rd_addr_q <= issue_last ? '0 : issue_addr + AddrW'(1);
                  end
               end else if (state_q == StPlaying) begin
                  // hw_stop: in-flight reads still drain
                  state_q   <= StLoaded;
                  rd_addr_q <= '0;
                  pending_q <= 1'b1;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

   // Waveform storage write port
   always_ff @(posedge dac_clk) begin
      if (beat) mem[wr_addr_q] <= bus.load_data;
   end

   // Read pipeline valids, flushed by sw_reset
   always_ff @(posedge dac_clk or negedge dac_reset_n) begin
      if (!dac_reset_n) begin
         pipe_valid_q <= '0;
      end else if (bus.sw_reset) begin
         pipe_valid_q <= '0;
      end else begin
         pipe_valid_q[0] <= issue;
         for (int i = 1; i < READ_LATENCY; i++) pipe_valid_q[i] <= pipe_valid_q[i-1];
      end
   end

   // Read pipeline data, qualified by the valids
   always_ff @(posedge dac_clk) begin
      pipe_data_q[0] <= mem[issue_addr];
      for (int i = 1; i < READ_LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
   end

   assign bus.load_ready       = load_ready;
   assign bus.load_depth       = depth_q;
   assign bus.load_depth_valid = depth_valid_q;
   assign bus.dac_valid        = pipe_valid_q[READ_LATENCY-1];
   assign bus.dac_data         = pipe_valid_q[READ_LATENCY-1] ? pipe_data_q[READ_LATENCY-1] : '0;
   assign bus.playback_done    = done_q;
endmodule

// File: tb/tb_dac_playback_buffer.sv
// Bench for dac_playback_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the load/playback rules.
module tb_dac_playback_buffer;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned LAT   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dac_playback_buffer_if #(.DWIDTH(DW), .BUFFER_DEPTH(DEPTH)) bus ();

   dac_playback_buffer #(
      .DWIDTH      (DW),
      .BUFFER_DEPTH(DEPTH),
      .READ_LATENCY(LAT)
   ) dut (
      .dac_clk    (clk),
      .dac_reset_n(rst_n),
      .bus        (bus)
   );

   typedef enum int {MEmpty, MLoading, MLoaded, MArmed, MPlaying} mstate_e;
   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } ent_t;

   mstate_e       ms = MEmpty;
   logic [DW-1:0] stored [DEPTH];
   ent_t          expq[$];
   int  nstored = 0, depth = 0, pidx = 0;
   bit  mloop = 1'b0, pending = 1'b0, cur_valid = 1'b0;
   bit  ldv_next = 1'b0, done_next = 1'b0, acc = 1'b0;
   int  cyc = 0, checks = 0, failures = 0;
   int  n_valid = 0, n_done = 0, n_ldv = 0, first_valid = -1, m_loads = 0, m_done = 0;
   int  got, s, v0, d0, l0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic set_in(input bit lv, input bit ll, input bit a, input bit st, input bit sp,
                         input bit sr);
      bus.load_valid = lv;
      bus.load_last  = ll;
      bus.arm        = a;
      bus.hw_start   = st;
      bus.hw_stop    = sp;
      bus.sw_reset   = sr;
   endtask

   // Issue the next waveform word; it shows up LAT cycles later
   task automatic play_one();
      ent_t e;
      e.due  = cyc + int'(LAT);
      e.data = stored[pidx];
      expq.push_back(e);
      pidx++;
      if (pidx == depth) begin
         pidx = 0;
         if (mloop) ms = MPlaying;
         else begin
            ms      = MLoaded;
            pending = 1'b1;
         end
      end else begin
         ms = MPlaying;
      end
   endtask

   // One clock cycle: model the inputs, advance, check every output
   task automatic step();
      bit            ready, pend_before;
      logic [DW-1:0] exp_data;
      #1;
      ready = (ms == MEmpty || ms == MLoading) && !bus.sw_reset;
      check("load_ready", 64'(bus.load_ready), 64'(ready));
      acc         = bus.load_valid && ready;
      ldv_next    = 1'b0;
      pend_before = pending;
      if (bus.sw_reset) begin
         ms      = MEmpty;
         nstored = 0;
         depth   = 0;
         pending = 1'b0;
         expq.delete();
      end else begin
         case (ms)
            MEmpty, MLoading: begin
               if (bus.load_valid) begin
                  stored[nstored] = bus.load_data;
                  nstored++;
                  if (bus.load_last || nstored == int'(DEPTH)) begin
                     depth    = nstored;
                     nstored  = 0;
                     ms       = MLoaded;
                     ldv_next = 1'b1;
                     m_loads++;
                  end else begin
                     ms = MLoading;
                  end
               end
            end
            MLoaded: if (bus.arm) ms = MArmed;
            MArmed: begin
               if (bus.hw_start && !bus.hw_stop) begin
                  mloop = bus.loop_mode;
                  pidx  = 0;
                  play_one();
               end
            end
            MPlaying: begin
               if (bus.hw_stop) begin
                  ms      = MLoaded;
                  pending = 1'b1;
               end else begin
                  play_one();
               end
            end
            default: ;
         endcase
      end
      // Done follows the last valid word once nothing else is in flight
      done_next = !bus.sw_reset && pend_before && cur_valid && expq.size() == 0;
      if (done_next) begin
         pending = 1'b0;
         m_done++;
      end
      @(posedge clk);
      #1;
      cyc++;
      cur_valid = expq.size() > 0 && expq[0].due == cyc;
      exp_data  = cur_valid ? expq[0].data : '0;
      check("dac_valid", 64'(bus.dac_valid), 64'(cur_valid));
      check("dac_data", 64'(bus.dac_data), 64'(exp_data));
      if (cur_valid) void'(expq.pop_front());
      check("load_depth_valid", 64'(bus.load_depth_valid), 64'(ldv_next));
      check("load_depth", 64'(bus.load_depth), 64'(depth));
      check("playback_done", 64'(bus.playback_done), 64'(done_next));
      if (bus.dac_valid) begin
         n_valid++;
         if (first_valid < 0) first_valid = cyc;
      end
      if (bus.playback_done) n_done++;
      if (bus.load_depth_valid) n_ldv++;
   endtask

   task automatic idle(input int n);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input bit a, input bit st, input bit sp, input bit sr);
      set_in(1'b0, 1'b0, a, st, sp, sr);
      step();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Word k carries value k; gap_pct sets the chance of a bubble per cycle
   task automatic load_words(input int n, input bit use_last, input int unsigned gap_pct,
                             input int budget, output int accepted);
      accepted = 0;
      for (int t = 0; t < budget && accepted < n; t++) begin
         bus.load_data = DW'(accepted);
         set_in($urandom_range(99) >= gap_pct, use_last && accepted == n - 1, 1'b0, 1'b0, 1'b0,
                1'b0);
         step();
         if (acc) accepted++;
      end
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.load_data = '0;
      bus.loop_mode = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_load_ready", 64'(bus.load_ready), 64'(0));
      check("rst_dac_valid", 64'(bus.dac_valid), 64'(0));
      check("rst_load_depth", 64'(bus.load_depth), 64'(0));
      check("rst_done", 64'(bus.playback_done), 64'(0));
      rst_n = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 40-word one-shot
      l0 = n_ldv;
      load_words(40, 1'b1, 0, 60, got);
      check("load40_count", 64'(got), 64'(40));
      idle(1);
      check("load40_ldv_pulses", 64'(n_ldv - l0), 64'(1));
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      v0 = n_valid; d0 = n_done; first_valid = -1; s = cyc;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(50);
      check("oneshot_latency", 64'(first_valid - s), 64'(LAT));
      check("oneshot_words", 64'(n_valid - v0), 64'(40));
      check("oneshot_done", 64'(n_done - d0), 64'(1));

      // Overfill: stops at DEPTH words without last
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      load_words(70, 1'b0, 20, 120, got);
      check("overfill_count", 64'(got), 64'(DEPTH));
      check("overfill_depth", 64'(bus.load_depth), 64'(DEPTH));
      v0 = n_valid;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(75);
      check("overfill_words", 64'(n_valid - v0), 64'(DEPTH));

      // Start without arm, start while empty
      v0 = n_valid; d0 = n_done;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(8);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(8);
      check("noarm_words", 64'(n_valid - v0), 64'(0));
      check("noarm_done", 64'(n_done - d0), 64'(0));
      load_words(5, 1'b1, 30, 40, got);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(12);
      check("after_noarm_words", 64'(n_valid - v0), 64'(5));

      // Looped 10 words, stop 25 cycles after start, then one-shot replay
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      load_words(10, 1'b1, 0, 20, got);
      bus.loop_mode = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      v0 = n_valid; d0 = n_done;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      bus.loop_mode = 1'b0;
      idle(24);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      idle(10);
      check("loop_words", 64'(n_valid - v0), 64'(25));
      check("loop_done", 64'(n_done - d0), 64'(1));
      v0 = n_valid;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(16);
      check("replay_words", 64'(n_valid - v0), 64'(10));

      // sw_reset mid-load, with a colliding load beat
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      l0 = n_ldv;
      load_words(20, 1'b0, 0, 30, got);
      bus.load_data = DW'(20);
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      idle(2);
      check("swrst_load_ldv", 64'(n_ldv - l0), 64'(0));
      load_words(3, 1'b1, 0, 10, got);
      v0 = n_valid;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(10);
      check("swrst_reload_words", 64'(n_valid - v0), 64'(3));

      // sw_reset during looped playback
      bus.loop_mode = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      bus.loop_mode = 1'b0;
      idle(6);
      d0 = n_done;
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      idle(8);
      check("swrst_play_done", 64'(n_done - d0), 64'(0));

      // sw_reset while armed
      load_words(4, 1'b1, 0, 10, got);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      v0 = n_valid;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      idle(8);
      check("swrst_armed_words", 64'(n_valid - v0), 64'(0));

      // Random traffic across all states
      for (int i = 0; i < 3000; i++) begin
         bus.load_data = $urandom;
         bus.loop_mode = 1'($urandom_range(1));
         set_in($urandom_range(99) < 60, $urandom_range(99) < 8, $urandom_range(99) < 10,
                $urandom_range(99) < 8, $urandom_range(99) < 3, $urandom_range(99) < 1);
         step();
      end
      idle(12);
      check("rand_ldv_total", 64'(n_ldv), 64'(m_loads));
      check("rand_done_total", 64'(n_done), 64'(m_done));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
